// File: rtl/serial_add_seq_pkg.sv
// Shared definitions for the bit-serial adder sequencer: the FSM state
// encoding and the default operand width.
package serial_add_seq_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/serial_add_seq_if.sv
// Operand/result bundle between a requester/consumer and the serial adder.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The source holds its payload and valid until that edge; the
// sink may drive ready independently of valid. start_* carries a/b/cin into
// the adder; done_* carries result/cout/ovf out of it. abort is a level that
// is only looked at while an addition is running.
interface serial_add_seq_if #(
    parameter int WIDTH = serial_add_seq_pkg::DEFAULT_WIDTH
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             abort;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             done_valid;
    logic             done_ready;

    // Adder side
    modport slave (
        input  start_valid, a, b, cin, abort, done_ready,
        output start_ready, result, cout, ovf, done_valid
    );

    // Requester/consumer side
    modport master (
        output start_valid, a, b, cin, abort, done_ready,
        input  start_ready, result, cout, ovf, done_valid
    );
endinterface

// File: rtl/serial_add_seq_all_adder.sv
// One-bit full-adder cell: the only arithmetic in the serial adder.
module all_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic ans,
    output logic carry_out
);

    // Sum and carry of three one-bit inputs
    always_comb begin
        ans       = a ^ b ^ carry_in;
        carry_out = (a & b) | (carry_in & (a ^ b));
    end

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder: one full-adder cell processes one bit per
// clock, LSB first, with the carry held in a register between bits.
// Accept on edge E0, bits on edges E1..EWIDTH, result valid from EWIDTH.
module serial_add_seq
    import serial_add_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_seq_if.slave   bus,
    output logic [1:0]        state_o
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    logic             cell_sum;
    logic             cell_co;

    all_adder u_cell (
        .a         (a_sr_q[0]),
        .b         (b_sr_q[0]),
        .carry_in  (carry_q),
        .ans       (cell_sum),
        .carry_out (cell_co)
    );

    // Next-state logic: load on accept, shift one bit per RUN edge, hold in DONE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                // start_ready is high throughout IDLE, so valid alone accepts
                if (bus.start_valid) begin
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    carry_d  = bus.cin;
                    cnt_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                if (bus.abort) begin
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    result_d = {cell_sum, result_q[WIDTH-1:1]};
                    carry_d  = cell_co;
                    a_sr_d   = a_sr_q >> 1;
                    b_sr_d   = b_sr_q >> 1;
                    if (cnt_q == LAST_BIT) begin
                        // carry_q is the carry into the MSB, cell_co the carry out
                        cout_d  = cell_co;
                        ovf_d   = carry_q ^ cell_co;
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                if (bus.done_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Handshake flags decoded straight from the state register
    always_comb begin
        bus.start_ready = (state_q == ST_IDLE);
        bus.done_valid  = (state_q == ST_DONE);
        bus.result      = result_q;
        bus.cout        = cout_q;
        bus.ovf         = ovf_q;
        state_o         = state_q;
    end

endmodule
